dcache_wb_ctrl: RTL and testbench
=================================

DCACHE_WB_CTRL -- requirements
Module: dcache_wb_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_SETS, default 16: number of sets; power of two, 2..64; tag width = 27 - log2(NUM_SETS).
REQ-002 The block SHALL have port clk_i, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_i, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port cpu_addr_i, input, 32 bits: byte address, word-aligned; [4:2] word, index above it, tag in the remaining upper bits.
REQ-005 The block SHALL have the CPU request ports cpu_MemRead_i (input, 1 bit), cpu_MemWrite_i (input, 1 bit) and cpu_data_i (input, 32 bits: store data).
REQ-006 The block SHALL have the CPU response ports cpu_data_o (output, 32 bits: load data) and cpu_stall_o (output, 1 bit: access not complete).
REQ-007 The block SHALL have the memory request ports mem_enable_o (output, 1), mem_write_o (output, 1), mem_addr_o (output, 32: line address, [4:0]=0) and mem_data_o (output, 256: write-back line).
REQ-008 The block SHALL have the memory response ports mem_ack_i (input, 1 bit: one-cycle completion pulse) and mem_data_i (input, 256 bits: refill line, valid with ack).

Function
REQ-009 Storage SHALL be 2 ways x NUM_SETS lines of 256 bits, each line with its own tag, valid bit and dirty bit, plus one LRU bit per set that names the least-recently-used way.
REQ-010 FSM states SHALL be IDLE=0, MISS, WRITEBACK, READMISS, READMISSOK; IDLE SHALL be the only state with cpu_stall_o allowed low.
REQ-011 Hit (valid and tag match, in IDLE) SHALL be combinational: cpu_stall_o=0, cpu_data_o=selected word, with the LRU bit updated at the next edge.
REQ-012 A write hit SHALL replace the addressed word at the next edge and set the dirty bit; the other 7 words SHALL be unchanged.
REQ-013 A miss (read or write) in IDLE SHALL drive cpu_stall_o=1 combinationally in the same cycle and move the FSM to MISS.
REQ-014 In MISS, the block SHALL select the victim: an invalid way first (way0 before way1), otherwise the LRU way; it SHALL go to WRITEBACK if the victim is valid and dirty, else to READMISS.
REQ-015 In WRITEBACK, outputs SHALL be mem_enable_o=1, mem_write_o=1, mem_addr_o={victim tag, index, 5'b0}, mem_data_o=victim line; on sampled mem_ack_i the FSM SHALL go to READMISS.
REQ-016 In READMISS, outputs SHALL be mem_enable_o=1, mem_write_o=0, mem_addr_o={cpu tag, index, 5'b0}; on sampled mem_ack_i the block SHALL write mem_data_i into the victim way (valid=1, dirty=0, new tag) and go to READMISSOK.
REQ-017 READMISSOK SHALL last one cycle and then go to IDLE, where the held request hits and completes per REQ-011/REQ-012.
REQ-018 Request outputs SHALL stay stable while mem_enable_o=1; mem_enable_o SHALL drop in the cycle after ack; ack with mem_enable_o=0 SHALL be ignored.
REQ-019 If cpu_MemRead_i and cpu_MemWrite_i are both 1, the access SHALL be treated as a write; with neither asserted, cpu_stall_o=0 and no state change.
REQ-020 The CPU SHALL hold its address and data stable while cpu_stall_o=1; the block SHALL not latch them.
REQ-021 Ack latency SHALL be unbounded, with ack allowed in the first enabled cycle; a clean miss SHALL stall for exactly ack latency + 3 cycles.

Reset
REQ-022 While rst_i=0, the FSM SHALL be IDLE; all valid, dirty and LRU bits SHALL be 0; mem_enable_o, mem_write_o, mem_addr_o, mem_data_o, cpu_data_o and cpu_stall_o SHALL be 0.
REQ-023 Reset SHALL act immediately, including mid-transaction: mem_enable_o falls without waiting for ack, a later stray ack SHALL be ignored, and data array contents SHALL be unspecified.

Verification
REQ-024 Scenario: reset; memory line 0 = 0x0000_1111_..._EEEE_FFFF (10-cycle ack); read 0x00000000 -> one read request to addr 0x00000000, stall 13 cycles, cpu_data_o=0xEEEEFFFF.
REQ-025 Scenario: after REQ-024, write 0x00000004 data 0x12345678 -> no stall, way dirty; then read 0x00000004 -> 0x12345678 with no stall.
REQ-026 Scenario: read 0x00000200 (fills way1, LRU->way0), then read 0x00000400 -> write-back to addr 0x00000000 carrying 0x12345678 in word1, then refill from 0x00000400.
REQ-027 Scenario: rst_i low while READMISS has mem_enable_o=1 -> mem_enable_o=0 and cpu_stall_o=0 at once; later read 0x00000000 misses again.
REQ-028 Scenario: memory acks in the first enabled cycle -> mem_enable_o high exactly 1 cycle per request; clean miss stalls 4 cycles.
REQ-029 Scenario: cpu_MemRead_i=cpu_MemWrite_i=1 on hit 0x00000008 data 0xA5A5A5A5 -> word2 written, dirty set.

Source files
------------

// File: rtl/dcache_wb_ctrl.sv
// Two-way set-associative write-back data cache controller with LRU replacement.
// Hits complete combinationally in IDLE; misses write back a dirty victim, then refill the line.
module dcache_wb_ctrl #(
  parameter int unsigned NUM_SETS = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [31:0]  cpu_addr_i,
  input  logic         cpu_MemRead_i,
  input  logic         cpu_MemWrite_i,
  input  logic [31:0]  cpu_data_i,
  output logic [31:0]  cpu_data_o,
  output logic         cpu_stall_o,
  output logic         mem_enable_o,
  output logic         mem_write_o,
  output logic [31:0]  mem_addr_o,
  output logic [255:0] mem_data_o,
  input  logic         mem_ack_i,
  input  logic [255:0] mem_data_i
);

  localparam int unsigned IDX_W = $clog2(NUM_SETS);
  localparam int unsigned TAG_W = 27 - IDX_W;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    MISS       = 3'd1,
    WRITEBACK  = 3'd2,
    READMISS   = 3'd3,
    READMISSOK = 3'd4
  } state_t;

  state_t state_q, state_d;
  logic   victim_q, victim_d;

  logic [7:0][31:0]              data_q [2][NUM_SETS];
  logic [TAG_W-1:0]              tag_q  [2][NUM_SETS];
  logic [1:0][NUM_SETS-1:0]      valid_q;
  logic [1:0][NUM_SETS-1:0]      dirty_q;
  logic [NUM_SETS-1:0]           lru_q;

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] cpu_tag;
  logic [2:0]       word;
  logic             req, is_write;
  logic [1:0]       hit_way;
  logic             hit, hit_sel, access_hit, refill;
  logic             stall;
  logic             unused_addr_bits;

  assign idx              = cpu_addr_i[5 +: IDX_W];
  assign cpu_tag          = cpu_addr_i[31 -: TAG_W];
  assign word             = cpu_addr_i[4:2];
  assign unused_addr_bits = ^cpu_addr_i[1:0];

  // A simultaneous read and write is handled as a write.
  assign req      = cpu_MemRead_i | cpu_MemWrite_i;
  assign is_write = cpu_MemWrite_i;

  assign hit_way[0] = valid_q[0][idx] && (tag_q[0][idx] == cpu_tag);
  assign hit_way[1] = valid_q[1][idx] && (tag_q[1][idx] == cpu_tag);
  assign hit        = |hit_way;
  assign hit_sel    = hit_way[1];
  assign access_hit = (state_q == IDLE) && req && hit;
  assign refill     = (state_q == READMISS) && mem_ack_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= IDLE;
      victim_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      state_q  <= state_d;
      victim_q <= victim_d;
    end
  end

  always_comb begin
    // NOTE: every output gets a default first; a path that skips an assignment would infer a latch.
    state_d      = state_q;
    victim_d     = victim_q;
    stall        = 1'b1;
    mem_enable_o = 1'b0;
    mem_write_o  = 1'b0;
    mem_addr_o   = '0;
    mem_data_o   = '0;
    unique case (state_q)
      IDLE: begin
        stall = req && !hit;
        if (req && !hit) state_d = MISS;
      end
      MISS: begin
        if (!valid_q[0][idx])      victim_d = 1'b0;
        else if (!valid_q[1][idx]) victim_d = 1'b1;
        else                       victim_d = lru_q[idx];
        state_d = (valid_q[victim_d][idx] && dirty_q[victim_d][idx]) ? WRITEBACK : READMISS;
      end
      WRITEBACK: begin
        mem_enable_o = 1'b1;
        mem_write_o  = 1'b1;
        mem_addr_o   = {tag_q[victim_q][idx], idx, 5'b0};
        mem_data_o   = data_q[victim_q][idx];
        if (mem_ack_i) state_d = READMISS;
      end
      READMISS: begin
        mem_enable_o = 1'b1;
        mem_addr_o   = {cpu_tag, idx, 5'b0};
        if (mem_ack_i) state_d = READMISSOK;
      end
      READMISSOK: state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  // Reset holds the FSM in IDLE, but a pending request would still look like a miss.
  assign cpu_stall_o = stall & rst_i;
  assign cpu_data_o  = access_hit ? data_q[hit_sel][idx][word] : '0;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
      lru_q   <= '0;
    end else if (refill) begin
      valid_q[victim_q][idx] <= 1'b1;
      dirty_q[victim_q][idx] <= 1'b0;
    end else if (access_hit) begin
      lru_q[idx] <= ~hit_sel;
      if (is_write) dirty_q[hit_sel][idx] <= 1'b1;
    end
  end

  // NOTE: line data and tags are not reset; valid bits alone decide whether their contents mean anything.
  always_ff @(posedge clk_i) begin
    if (refill) begin
      data_q[victim_q][idx] <= mem_data_i;
      tag_q[victim_q][idx]  <= cpu_tag;
    end else if (access_hit && is_write) begin
      data_q[hit_sel][idx][word] <= cpu_data_i;
    end
  end

endmodule

// File: tb/tb_dcache_wb_ctrl.sv
// Directed bench for dcache_wb_ctrl: a latency-programmable memory model logs every
// acknowledged request; hits, misses, write-backs and mid-transaction reset are checked.
module tb_dcache_wb_ctrl;

  localparam logic [255:0] LINE0 =
    256'h00001111_22223333_44445555_66667777_88889999_AAAABBBB_CCCCDDDD_EEEEFFFF;

  typedef struct {
    logic         we;
    logic [31:0]  addr;
    logic [255:0] data;
  } mreq_t;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b0;
  logic [31:0]  cpu_addr_i = '0;
  logic         cpu_MemRead_i = 1'b0;
  logic         cpu_MemWrite_i = 1'b0;
  logic [31:0]  cpu_data_i = '0;
  logic [31:0]  cpu_data_o;
  logic         cpu_stall_o;
  logic         mem_enable_o;
  logic         mem_write_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o;
  logic         mem_ack_i = 1'b0;
  logic [255:0] mem_data_i = '0;

  int n_tests = 0;
  int n_fail  = 0;

  int           lat = 10;
  int           req_cnt = 0;
  int           en_cycles = 0;
  logic         stray_ack = 1'b0;
  logic [255:0] mem [logic [31:0]];
  mreq_t        log_q [$];

  always #5 clk_i = ~clk_i;

  dcache_wb_ctrl #(.NUM_SETS(16)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .cpu_addr_i     (cpu_addr_i),
    .cpu_MemRead_i  (cpu_MemRead_i),
    .cpu_MemWrite_i (cpu_MemWrite_i),
    .cpu_data_i     (cpu_data_i),
    .cpu_data_o     (cpu_data_o),
    .cpu_stall_o    (cpu_stall_o),
    .mem_enable_o   (mem_enable_o),
    .mem_write_o    (mem_write_o),
    .mem_addr_o     (mem_addr_o),
    .mem_data_o     (mem_data_o),
    .mem_ack_i      (mem_ack_i),
    .mem_data_i     (mem_data_i)
  );

  function automatic logic [255:0] mem_line(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return LINE0 ^ {8{a}};
  endfunction

  // Memory: acks in the lat-th enabled cycle of each request, ack valid for one cycle.
  always @(negedge clk_i) begin
    if (rst_i && mem_enable_o) begin
      en_cycles++;
      req_cnt++;
      if (req_cnt == lat) begin
        mreq_t r;
        req_cnt   = 0;
        mem_ack_i = 1'b1;
        r.we   = mem_write_o;
        r.addr = mem_addr_o;
        r.data = mem_data_o;
        if (mem_write_o) mem[mem_addr_o] = mem_data_o;
        else             mem_data_i = mem_line(mem_addr_o);
        log_q.push_back(r);
      end else begin
        mem_ack_i = 1'b0;
      end
    end else begin
      req_cnt   = 0;
      mem_ack_i = stray_ack;
    end
  end

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One CPU access; returns the number of stalled cycles and the data seen in the completing cycle.
  task automatic access(input logic [31:0] a, input logic rd, input logic wr, input logic [31:0] d,
                        output int stalls, output logic [31:0] rdata);
    @(posedge clk_i); #1;
    cpu_addr_i     = a;
    cpu_MemRead_i  = rd;
    cpu_MemWrite_i = wr;
    cpu_data_i     = d;
    stalls = 0;
    forever begin
      @(negedge clk_i);
      if (!cpu_stall_o) break;
      stalls++;
      if (stalls > 300) begin
        n_tests++;
        n_fail++;
        $display("FAIL timeout: access %0h still stalled after %0d cycles", a, stalls);
        break;
      end
    end
    rdata = cpu_data_o;
    @(posedge clk_i); #1;
    cpu_MemRead_i  = 1'b0;
    cpu_MemWrite_i = 1'b0;
  endtask

  initial begin
    int              st;
    int              en0;
    logic [31:0]     rd;
    logic [7:0][31:0] exp_line;

    // Reset with a request pending: every output must stay low.
    cpu_MemRead_i = 1'b1;
    repeat (3) @(negedge clk_i);
    check("rst_stall", cpu_stall_o, 0);
    check("rst_en", mem_enable_o, 0);
    check("rst_we", mem_write_o, 0);
    check("rst_maddr", mem_addr_o, 0);
    check("rst_mdata", mem_data_o, 0);
    check("rst_cdata", cpu_data_o, 0);
    cpu_MemRead_i = 1'b0;
    #2 rst_i = 1'b1;

    // Clean read miss with 10-cycle ack.
    lat = 10;
    log_q.delete();
    access(32'h0, 1, 0, 0, st, rd);
    check("miss0_stall", st, 13);
    check("miss0_data", rd, 32'hEEEEFFFF);
    check("miss0_nreq", log_q.size(), 1);
    if (log_q.size() >= 1) begin
      check("miss0_we", log_q[0].we, 0);
      check("miss0_addr", log_q[0].addr, 32'h0);
    end

    // Write hit, read-back, and a read+write treated as a write.
    log_q.delete();
    access(32'h4, 0, 1, 32'h12345678, st, rd);
    check("wr4_stall", st, 0);
    access(32'h4, 1, 0, 0, st, rd);
    check("rd4_stall", st, 0);
    check("rd4_data", rd, 32'h12345678);
    access(32'h8, 1, 1, 32'hA5A5A5A5, st, rd);
    check("rw8_stall", st, 0);
    access(32'h8, 1, 0, 0, st, rd);
    check("rd8_data", rd, 32'hA5A5A5A5);
    access(32'h0, 1, 0, 0, st, rd);
    check("rd0_other_word", rd, 32'hEEEEFFFF);
    check("hits_nreq", log_q.size(), 0);

    // Fill way1, then evict the dirty way0 line.
    log_q.delete();
    access(32'h200, 1, 0, 0, st, rd);
    check("miss200_stall", st, 13);
    check("miss200_data", rd, 32'hEEEEFDFF);
    check("miss200_nreq", log_q.size(), 1);
    log_q.delete();
    access(32'h400, 1, 0, 0, st, rd);
    check("miss400_stall", st, 23);
    check("miss400_data", rd, 32'hEEEEFBFF);
    check("miss400_nreq", log_q.size(), 2);
    if (log_q.size() >= 2) begin
      exp_line    = LINE0;
      exp_line[1] = 32'h12345678;
      exp_line[2] = 32'hA5A5A5A5;
      check("wb_we", log_q[0].we, 1);
      check("wb_addr", log_q[0].addr, 32'h0);
      check("wb_data", log_q[0].data, exp_line);
      check("wb_word1", log_q[0].data[63:32], 32'h12345678);
      check("refill_we", log_q[1].we, 0);
      check("refill_addr", log_q[1].addr, 32'h400);
    end
    access(32'h200, 1, 0, 0, st, rd);
    check("hit200_stall", st, 0);
    check("hit200_data", rd, 32'hEEEEFDFF);

    // No request on an uncached address: no stall, no memory traffic.
    @(posedge clk_i); #1;
    cpu_addr_i = 32'h1000;
    repeat (2) @(negedge clk_i);
    check("noreq_stall", cpu_stall_o, 0);
    check("noreq_en", mem_enable_o, 0);

    // Reset in the middle of a refill, followed by a stray ack.
    lat = 1000;
    @(posedge clk_i); #1;
    cpu_addr_i    = 32'h600;
    cpu_MemRead_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      if (mem_enable_o) break;
    end
    check("mid_en_before", mem_enable_o, 1);
    check("mid_addr_before", mem_addr_o, 32'h600);
    #2 rst_i = 1'b0;
    #1;
    check("mid_rst_en", mem_enable_o, 0);
    check("mid_rst_stall", cpu_stall_o, 0);
    cpu_MemRead_i = 1'b0;
    stray_ack = 1'b1;
    repeat (2) @(negedge clk_i);
    #2 rst_i = 1'b1;
    repeat (2) @(negedge clk_i);
    stray_ack = 1'b0;
    check("stray_en", mem_enable_o, 0);
    check("stray_stall", cpu_stall_o, 0);

    lat = 10;
    log_q.delete();
    access(32'h0, 1, 0, 0, st, rd);
    check("rerd0_stall", st, 13);
    check("rerd0_data", rd, 32'hEEEEFFFF);
    check("rerd0_nreq", log_q.size(), 1);
    access(32'h4, 1, 0, 0, st, rd);
    check("rerd4_stall", st, 0);
    check("rerd4_data", rd, 32'h12345678);

    // Ack in the first enabled cycle: clean and dirty misses.
    lat = 1;
    en0 = en_cycles;
    access(32'h800, 1, 0, 0, st, rd);
    check("fast_clean_stall", st, 4);
    check("fast_clean_en", en_cycles - en0, 1);
    check("fast_clean_data", rd, 32'hEEEEF7FF);
    access(32'h804, 0, 1, 32'hDEADBEEF, st, rd);
    check("fast_wr_stall", st, 0);
    access(32'h0, 1, 0, 0, st, rd);
    check("fast_hit0_stall", st, 0);
    log_q.delete();
    en0 = en_cycles;
    access(32'hA00, 1, 0, 0, st, rd);
    check("fast_dirty_stall", st, 5);
    check("fast_dirty_en", en_cycles - en0, 2);
    check("fast_dirty_data", rd, 32'hEEEEF5FF);
    check("fast_dirty_nreq", log_q.size(), 2);
    if (log_q.size() >= 2) begin
      exp_line    = LINE0 ^ {8{32'h800}};
      exp_line[1] = 32'hDEADBEEF;
      check("fast_wb_addr", log_q[0].addr, 32'h800);
      check("fast_wb_data", log_q[0].data, exp_line);
      check("fast_refill_addr", log_q[1].addr, 32'hA00);
    end
    @(negedge clk_i);
    check("final_en", mem_enable_o, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
